packet_disassembler: RTL
========================

// Module: packet_disassembler
// PURPOSE
//  HDMI sink-side data island packet parser, the receive-end counterpart of the source packet path.
//  - Input: one 9-bit packet_data symbol per clk_pixel while data_island_period is high.
//    The symbol comes from the TERC4-decoded channel 0 bit 2 plus channels 1/2.
//  - Reassembles the 24-bit header and four 56-bit subpackets over 32 symbols.
//  - Recomputes BCH ECC per block, presents the packet with per-block error flags and a one-cycle valid.
// PARAMETERS
//  DROP_ON_ERROR  0  1: packet_valid suppressed when any ECC error; 0: always pulse, flags report errors
// PORTS
//  clk_pixel           in   1       pixel clock
//  reset               in   1       async active-high reset
//  data_island_period  in   1       high for each packet symbol (32 per packet, back-to-back allowed)
//  packet_data         in   9       symbol: [0]=BCH4 bit, [4:1]=BCH0-3 even bit, [8:5]=BCH0-3 odd bit
//  header              out  24      last decoded header (HB0 in [7:0])
//  sub                 out  4x56    last decoded subpackets (sub[k][7:0] = SBk byte 0)
//  header_ecc_error    out  1       received BCH4 parity != computed
//  sub_ecc_error       out  4       bit k: received BCHk parity != computed
//  packet_valid        out  1       one-cycle pulse: outputs above updated this cycle
//  counter             out  5       current symbol index within packet
// BEHAVIOUR
//  Reset (async, any time): counter=0, all ECC accumulators=0, header=0, sub=0, error flags=0, packet_valid=0.
//   - A partially received packet is discarded.
//  Symbol counter:
//   - Increments by 1 on each clk_pixel with data_island_period=1; wraps 31->0.
//   - Falling data_island_period with counter!=0 = abort: counter and accumulators clear next edge, no packet_valid.
//   - Counter is 0 whenever data_island_period is low.
//  Bit mapping at counter c:
//   - BCH4 bit c = packet_data[0].
//   - BCHk bit 2c = packet_data[1+k]; BCHk bit 2c+1 = packet_data[5+k].
//   - BCH4 bits 0-23 are the header, bits 24-31 its parity.
//   - BCHk bits 0-55 are subpacket k, bits 56-63 its parity.
//  ECC step: e' = (e[0]^b) ? (e>>1)^8'b10000011 : (e>>1); accumulators start at 8'd0.
//   - Header: one step per cycle for c<24.
//   - Subpackets: two steps per cycle (even bit, then odd bit) for c<28.
//   - Accumulators hold for c>=28 and clear on the c==31 edge.
//  Parity capture: received parity bits are shift/indexed into 8-bit registers for c>=24 (BCH4) and c>=28 (BCHk).
//  Completion, on the clk_pixel edge where data_island_period=1 and c==31:
//   - Compare uses the final parity bits from this cycle's packet_data, merged combinationally.
//   - header, sub, error flags are registered; packet_valid=1 for exactly the next cycle.
//   - Latency: outputs visible 1 cycle after the last symbol is sampled.
//   - DROP_ON_ERROR=1 with any error: header/sub/flags still update, packet_valid stays 0.
//  Outputs hold between packets; packet_valid=0 except on the completion cycle.
//  Back-to-back packets: the c==31 clear and the next packet's c==0 are seamless.
//   - packet_valid may pulse every 32 cycles.
//  Error detection only, no correction.
// TESTING
//  1 All-zero packet (header=0, subs=0, parity=0) over 32 symbols -> packet_valid pulse at cycle 33, all error flags 0, header=0.
//  2 Packet encoded by golden ECC model (header 24'h000001, sub[0]=56'h0000_0000_1800_00, others 0) -> header/sub match, flags 0.
//  3 Same packet with header bit 5 flipped -> header_ecc_error=1, sub_ecc_error=4'b0000.
//    Same packet with sub[2] bit 40 flipped -> sub_ecc_error=4'b0100.
//  4 data_island_period dropped at counter=10, then a clean 32-symbol packet -> no pulse for the aborted packet, one correct pulse for the second.
//  5 Three back-to-back packets (96 cycles) -> three pulses 32 cycles apart, each with correct contents.
//  6 reset asserted at counter=17 then released -> outputs 0 immediately; next full packet decodes clean.
//    DROP_ON_ERROR=1 with a flipped bit -> no packet_valid, flags set.

Source files
------------

// File: rtl/packet_disassembler.sv
// HDMI data island packet parser: reassembles header and four subpackets from 32 symbols
// and recomputes the BCH parity of each block to report per-block errors.
module packet_disassembler #(
  parameter bit DROP_ON_ERROR = 1'b0
) (
  input  logic         clk_pixel_i,
  input  logic         reset_i,
  input  logic         data_island_period_i,
  input  logic [8:0]   packet_data_i,
  output logic [23:0]  header_o,
  output logic [223:0] sub_o,
  output logic         header_ecc_error_o,
  output logic [3:0]   sub_ecc_error_o,
  output logic         packet_valid_o,
  output logic [4:0]   counter_o
);

  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    logic [7:0] sh;
    sh = {1'b0, e[7:1]};
    if (e[0] ^ b) begin
      return sh ^ 8'h83;
    end else begin
      return sh;
    end
  endfunction

  logic [4:0]        counter_q, counter_d;
  logic [7:0]        hdr_ecc_q, hdr_ecc_d;
  logic [3:0][7:0]   sub_ecc_q, sub_ecc_d;
  logic [23:0]       hdr_buf_q, hdr_buf_d;
  logic [3:0][55:0]  sub_buf_q, sub_buf_d;
  logic [7:0]        hdr_par_q, hdr_par_d;
  logic [3:0][7:0]   sub_par_q, sub_par_d;
  logic [23:0]       header_q, header_d;
  logic [3:0][55:0]  sub_q, sub_d;
  logic              hdr_err_q, hdr_err_d;
  logic [3:0]        sub_err_q, sub_err_d;
  logic              valid_q, valid_d;

  // Symbol assembly, ECC accumulation and completion of a packet at symbol 31.
  always_comb begin
    counter_d = counter_q;
    hdr_ecc_d = hdr_ecc_q;
    sub_ecc_d = sub_ecc_q;
    hdr_buf_d = hdr_buf_q;
    sub_buf_d = sub_buf_q;
    hdr_par_d = hdr_par_q;
    sub_par_d = sub_par_q;
    header_d  = header_q;
    sub_d     = sub_q;
    hdr_err_d = hdr_err_q;
    sub_err_d = sub_err_q;
    valid_d   = 1'b0;
    if (data_island_period_i) begin
      counter_d = counter_q + 5'd1;
      if (counter_q < 5'd24) begin
        hdr_ecc_d            = bch_step(hdr_ecc_q, packet_data_i[0]);
        hdr_buf_d[counter_q] = packet_data_i[0];
      end else begin
        hdr_par_d[counter_q[2:0]] = packet_data_i[0];
      end
      for (int k = 0; k < 4; k++) begin
        if (counter_q < 5'd28) begin
          sub_ecc_d[k] = bch_step(bch_step(sub_ecc_q[k], packet_data_i[1+k]), packet_data_i[5+k]);
          sub_buf_d[k][{counter_q, 1'b0}] = packet_data_i[1+k];
          sub_buf_d[k][{counter_q, 1'b1}] = packet_data_i[5+k];
        end else begin
          sub_par_d[k][{counter_q[1:0], 1'b0}] = packet_data_i[1+k];
          sub_par_d[k][{counter_q[1:0], 1'b1}] = packet_data_i[5+k];
        end
      end
      // The parity _d values already carry this cycle's final bits.
      if (counter_q == 5'd31) begin
        header_d  = hdr_buf_q;
        sub_d     = sub_buf_q;
        hdr_err_d = (hdr_par_d != hdr_ecc_q);
        for (int k = 0; k < 4; k++) begin
          sub_err_d[k] = (sub_par_d[k] != sub_ecc_q[k]);
        end
        valid_d   = ~(DROP_ON_ERROR & (hdr_err_d | (|sub_err_d)));
        hdr_ecc_d = 8'd0;
        sub_ecc_d = {4{8'd0}};
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      counter_d = 5'd0;
      hdr_ecc_d = 8'd0;
      sub_ecc_d = {4{8'd0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk_pixel_i or posedge reset_i) begin
    if (reset_i) begin
      counter_q <= 5'd0;
      hdr_ecc_q <= 8'd0;
      sub_ecc_q <= {4{8'd0}};
      hdr_buf_q <= 24'd0;
      sub_buf_q <= {4{56'd0}};
      hdr_par_q <= 8'd0;
      sub_par_q <= {4{8'd0}};
      header_q  <= 24'd0;
      sub_q     <= {4{56'd0}};
      hdr_err_q <= 1'b0;
      sub_err_q <= 4'd0;
      valid_q   <= 1'b0;
    end else begin
      counter_q <= counter_d;
      hdr_ecc_q <= hdr_ecc_d;
      sub_ecc_q <= sub_ecc_d;
      hdr_buf_q <= hdr_buf_d;
      sub_buf_q <= sub_buf_d;
      hdr_par_q <= hdr_par_d;
      sub_par_q <= sub_par_d;
      header_q  <= header_d;
      sub_q     <= sub_d;
      hdr_err_q <= hdr_err_d;
      sub_err_q <= sub_err_d;
      valid_q   <= valid_d;
    end
  end

  assign header_o           = header_q;
  assign sub_o              = sub_q;
  assign header_ecc_error_o = hdr_err_q;
  assign sub_ecc_error_o    = sub_err_q;
  assign packet_valid_o     = valid_q;
  assign counter_o          = counter_q;

endmodule
